// File: rtl/timer_pkg.sv
// Shared defaults for the memory-mapped cycle timer: bus width and the two
// decoded I/O addresses. The top level exposes these as overridable parameters.
package timer_pkg;

   localparam int unsigned TIMER_WIDTH        = 64;
   localparam logic [63:0] TIMER_ADDR_DEFAULT = 64'hFFFF_001C;
   localparam logic [63:0] ACK_ADDR_DEFAULT   = 64'hFFFF_006C;

endpackage

// File: rtl/timer_reg.sv
// WIDTH-wide register with an asynchronous, active-high reset to RST_VAL and
// a load enable. It is used for both the cycle counter and the compare value.
module timer_reg #(
   parameter int unsigned      WIDTH   = 64,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)     o_q <= RST_VAL;
      else if (i_en) o_q <= i_d;
   end

endmodule

// File: rtl/timer.sv
// Memory-mapped free-running cycle timer. It provides a readable counter, a
// writable compare register and a sticky interrupt that is cleared by a store
// to the acknowledge address.
module timer
   import timer_pkg::*;
#(
   parameter int unsigned      WIDTH      = TIMER_WIDTH,
   parameter logic [WIDTH-1:0] TIMER_ADDR = WIDTH'(TIMER_ADDR_DEFAULT),
   parameter logic [WIDTH-1:0] ACK_ADDR   = WIDTH'(ACK_ADDR_DEFAULT)
) (
   output logic             TimerInterrupt,
   output logic [WIDTH-1:0] cycle,
   output logic             TimerAddress,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] address,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic             clock,
   input  logic             reset
);

   logic             w_hit_timer;
   logic             w_hit_ack;
   logic             w_timer_read;
   logic             w_timer_write;
   logic             w_ack;
   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] w_compare;
   logic             r_interrupt;

   assign w_hit_timer   = (address == TIMER_ADDR);
   assign w_hit_ack     = (address == ACK_ADDR);
   assign w_timer_read  = MemRead  & w_hit_timer;
   assign w_timer_write = MemWrite & w_hit_timer;
   assign w_ack         = MemWrite & w_hit_ack;

   // The counter runs every cycle and wraps naturally at 2^WIDTH.
   timer_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL ('0)
   ) u_count (
      .clock (clock),
      .reset (reset),
      .i_en  (1'b1),
      .i_d   (w_count + WIDTH'(1)),
      .o_q   (w_count)
   );

   // Resetting the compare value to all ones keeps the interrupt quiet until software arms it.
   timer_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL ('1)
   ) u_compare (
      .clock (clock),
      .reset (reset),
      .i_en  (w_timer_write),
      .i_d   (data),
      .o_q   (w_compare)
   );

   // An acknowledge overrides a match in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                       r_interrupt <= 1'b0;
      else if (w_ack)                  r_interrupt <= 1'b0;
      else if (w_count == w_compare)   r_interrupt <= 1'b1;
   end

   assign TimerInterrupt = r_interrupt;
   assign cycle          = w_timer_read ? w_count : '0;
   assign TimerAddress   = w_hit_timer | w_hit_ack;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed vector table, hand-written corner
// sequences and randomized traffic checked against an arithmetic model.
module tb_timer;

   localparam logic [63:0] TA = 64'hFFFF_001C;
   localparam logic [63:0] AA = 64'hFFFF_006C;
   localparam logic [63:0] OA = 64'h0000_1000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        TimerInterrupt;
   logic [63:0] cycle;
   logic        TimerAddress;
   logic [63:0] data    = '0;
   logic [63:0] address = '0;
   logic        MemRead  = 1'b0;
   logic        MemWrite = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [63:0] m_cnt = '0;
   logic [63:0] m_cmp = '1;
   logic        m_irq = 1'b0;

   timer dut (
      .TimerInterrupt (TimerInterrupt),
      .cycle          (cycle),
      .TimerAddress   (TimerAddress),
      .data           (data),
      .address        (address),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .clock          (clock),
      .reset          (reset)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] dat;
      logic [63:0] e_cycle;
      logic        e_taddr;
      logic        e_irq;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] addr,
                               input logic [63:0] dat, input logic [63:0] e_cycle,
                               input logic e_taddr, input logic e_irq);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.dat = dat;
      v.e_cycle = e_cycle; v.e_taddr = e_taddr; v.e_irq = e_irq;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] dat);
      MemRead = rd; MemWrite = wr; address = addr; data = dat;
   endtask

   // Reference behaviour of one rising edge, stated directly from the rules.
   task automatic model_edge(input logic rd, input logic wr, input logic [63:0] addr,
                             input logic [63:0] dat);
      if (wr && addr == AA)  m_irq = 1'b0;
      else if (m_cnt == m_cmp) m_irq = 1'b1;
      if (wr && addr == TA)  m_cmp = dat;
      m_cnt = m_cnt + 64'd1;
      if (rd) begin end
   endtask

   task automatic model_step(input string tag, input logic rd, input logic wr,
                             input logic [63:0] addr, input logic [63:0] dat);
      drive(rd, wr, addr, dat);
      #1;
      check({tag, ".cycle"}, cycle, (rd && addr == TA) ? m_cnt : 64'd0);
      check({tag, ".taddr"}, 64'(TimerAddress), 64'(addr == TA || addr == AA));
      check({tag, ".irq"}, 64'(TimerInterrupt), 64'(m_irq));
      @(posedge clock);
      model_edge(rd, wr, addr, dat);
      @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) vecs[i] = mk(1, 0, TA, 0, 64'(i), 1, 0);
      vecs[5]  = mk(0, 1, TA, 64'd6,  0,  1, 0);
      vecs[6]  = mk(1, 0, TA, 0,      6,  1, 0);
      vecs[7]  = mk(1, 0, TA, 0,      7,  1, 1);
      vecs[8]  = mk(1, 0, TA, 0,      8,  1, 1);
      vecs[9]  = mk(0, 1, AA, 0,      0,  1, 1);
      vecs[10] = mk(1, 0, TA, 0,      10, 1, 0);
      vecs[11] = mk(1, 0, OA, 0,      0,  0, 0);
      vecs[12] = mk(0, 1, OA, 64'd13, 0,  0, 0);
      vecs[13] = mk(1, 0, TA, 0,      13, 1, 0);
      vecs[14] = mk(1, 0, TA, 0,      14, 1, 0);
      vecs[15] = mk(1, 1, TA, 64'd17, 15, 1, 0);
      vecs[16] = mk(0, 0, 64'd0, 0,   0,  0, 0);
      vecs[17] = mk(0, 1, AA, 0,      0,  1, 0);
      vecs[18] = mk(1, 0, TA, 0,      18, 1, 0);
      vecs[19] = mk(1, 0, TA, 0,      19, 1, 0);

      // Reset state, observed while reset is still asserted.
      @(posedge clock);
      @(negedge clock);
      drive(1, 0, TA, 0);
      #1;
      check("reset.cycle", cycle, 64'd0);
      check("reset.irq", 64'(TimerInterrupt), 64'd0);
      check("reset.taddr", 64'(TimerAddress), 64'd1);
      reset = 1'b0;

      // Directed table; the model tracks along so later phases continue from it.
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dat);
         #1;
         check($sformatf("vec%0d.cycle", i), cycle, vecs[i].e_cycle);
         check($sformatf("vec%0d.taddr", i), 64'(TimerAddress), 64'(vecs[i].e_taddr));
         check($sformatf("vec%0d.irq", i), 64'(TimerInterrupt), 64'(vecs[i].e_irq));
         @(posedge clock);
         model_edge(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dat);
         @(negedge clock);
      end

      // Arm two counts ahead and confirm the interrupt fires.
      model_step("arm", 0, 1, TA, m_cnt + 64'd2);
      for (int i = 0; i < 3; i++) model_step("fire", 1, 0, TA, 0);
      check("fire.set", 64'(TimerInterrupt), 64'd1);

      // Reset asserted between edges clears state without waiting for a clock.
      drive(1, 0, TA, 0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("midrst.irq", 64'(TimerInterrupt), 64'd0);
      check("midrst.cycle", cycle, 64'd0);
      m_cnt = '0; m_cmp = '1; m_irq = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) model_step("postrst", 1, 0, TA, 0);
      check("postrst.quiet", 64'(TimerInterrupt), 64'd0);

      // A compare value already passed must not fire.
      model_step("passed", 0, 1, TA, m_cnt - 64'd3);
      for (int i = 0; i < 6; i++) model_step("passed_run", 1, 0, TA, 0);
      check("passed.quiet", 64'(TimerInterrupt), 64'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic        rd, wr;
         logic [63:0] addr, dat;
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0, 1:    addr = TA;
            2:       addr = AA;
            default: addr = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 2) != 0) dat = m_cnt + 64'($urandom_range(0, 6));
         else                           dat = m_cnt - 64'($urandom_range(1, 6));
         model_step("rand", rd, wr, addr, dat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
